aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Iterative AES-128 encryption sequencer. Accepts one plaintext block and walks it through NR rounds.
- Fetches each round key from an external key store over a req/ack interface.
- Issues each round to a shared round datapath (sub_bytes/shift_rows/mix_cols/add_round_key) over a valid/done handshake.
- Applies the initial AddRoundKey itself; returns ciphertext over a valid/ready output.

Parameters:
- NR, 10: number of rounds. Round NR is the final round, with MixColumns bypassed.
- RND_TIMEOUT, 64: max cycles in WAIT before error. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start_valid  in  1  plaintext offered
- start_ready  out  1  controller can accept; high only in IDLE
- pt_in  in  128  plaintext, sampled on the start handshake
- rk_req  out  1  round-key request
- rk_idx  out  4  round-key index, 0..NR
- rk_ack  in  1  rk_data valid this cycle
- rk_data  in  128  round key
- rnd_valid  out  1  single-cycle round issue pulse
- rnd_state  out  128  round input state (the state register)
- rnd_key  out  128  round key (the key register)
- rnd_final  out  1  bypass mix_cols; high when round == NR
- rnd_done  in  1  round result valid
- rnd_result  in  128  round output state
- ct_valid  out  1  ciphertext available
- ct_ready  in  1  consumer accepts
- ct_out  out  128  ciphertext (the state register)
- busy  out  1  high whenever FSM != IDLE
- round_cnt  out  4  current round index
- err  out  1  watchdog error, sticky until reset

Behaviour:
- Reset (rst = 0, asynchronous): FSM = IDLE. state_reg, key_reg and round_cnt = 0. All outputs = 0 except start_ready = 1.
- Reset mid-operation discards all in-flight work; a later rnd_done or rk_ack is ignored.
- IDLE:
  - start_ready = 1.
  - On start_valid & start_ready: state_reg <= pt_in, round_cnt <= 0, go to KEY.
- KEY:
  - rk_req = 1, rk_idx = round_cnt; held until rk_ack is sampled high. rk_ack in the same cycle is legal.
  - On ack with round_cnt == 0: state_reg <= state_reg ^ rk_data, round_cnt <= 1, stay in KEY.
  - On ack otherwise: key_reg <= rk_data, go to ISSUE.
  - rk_ack while rk_req = 0 is ignored.
- ISSUE:
  - rnd_valid = 1 for exactly one cycle; rnd_final = (round_cnt == NR); go to WAIT.
  - rnd_done in ISSUE is ignored. Datapath latency is >= 1 cycle.
- WAIT: on rnd_done, state_reg <= rnd_result.
  - If round_cnt == NR: go to OUT.
  - Else: round_cnt <= round_cnt + 1, go to KEY.
- OUT:
  - ct_valid = 1, ct_out stable.
  - On ct_ready: go to IDLE. A new start is accepted no earlier than the following cycle.
  - ct_ready while ct_valid = 0 is ignored.
- rnd_state and rnd_key remain stable from ISSUE until rnd_done.
- Latency with zero-wait rk_ack and rnd_done in the first WAIT cycle:
  - ct_valid rises 32 clock edges after the start handshake edge.
  - Formula: 2 + 3*NR.
- round_cnt never exceeds NR; no wrap-around.

Optional Feature:
- Macro: AES_CTRL_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching RND_TIMEOUT without rnd_done: err <= 1, FSM goes to IDLE, state_reg is cleared. ct_valid is not asserted.
  - err clears only on reset.
- Undefined: err tied to 0; the FSM waits in WAIT indefinitely.

Decomposition:
- Package aes_pkg:
  - AES_BLK_W = 128 and AES_NR_128 = 10.
  - Enum ctrl_state_e {IDLE, KEY, ISSUE, WAIT, OUT}.
  - Typedef aes_blk_t = logic [127:0].
- No sub-module is needed. The optional watchdog may be a small sub-module, aes_ctrl_watchdog.

Test Plan:
- FIPS-197 B vector:
  - Stimulus: pt 3243f6a8885a308d313198a2e0370734; key store holds expansion of key 2b7e151628aed2a6abf7158809cf4f3c; behavioural round model.
  - Required: ct_out = 3925841d02dc09fbdc118597196a0b32; ct_valid 32 edges after start; rnd_final high only on round 10.
- Key-store stalls:
  - Stimulus: rk_ack delayed 3 cycles per request.
  - Required: rk_idx stable while rk_req is held; same ciphertext; total latency 32 + 33.
- Output backpressure and busy start:
  - Stimulus: hold ct_ready = 0 for 5 cycles; assert start_valid continuously.
  - Required: ct_out stable; start_ready = 0 until the cycle after the ct handshake; second block is then accepted.
- Spurious datapath done:
  - Stimulus: assert rnd_done during ISSUE.
  - Required: ignored; state_reg updates only on the WAIT-cycle rnd_done.
- Reset mid-round:
  - Stimulus: rst low at round 5 during WAIT.
  - Required: busy = 0, ct_valid = 0, round_cnt = 0 immediately (asynchronous); the next start produces the correct ciphertext.
- With AES_CTRL_TIMEOUT_EN:
  - Stimulus: rnd_done never asserted.
  - Required: err = 1 after 64 WAIT cycles; FSM returns to IDLE with start_ready = 1.

Source files
------------

// File: rtl/aes_round_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and constants for the iterative AES-128 round controller.
//   AES_BLK_W    : width of one AES block / round key (128)
//   AES_NR_128   : number of rounds for AES-128 (10)
//   RND_IDX_W    : width of the round index (holds 0..AES_NR_128)
//   aes_blk_t    : one 128-bit block
//   rnd_idx_t    : round index
//   ctrl_state_e : controller FSM states
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_NR_128 = 10;
  localparam int RND_IDX_W  = 4;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;
  typedef logic [RND_IDX_W-1:0] rnd_idx_t;

  // IDLE  : waiting for a plaintext block
  // KEY   : requesting round key rnd_idx from the key store
  // ISSUE : one-cycle round issue to the shared datapath
  // WAIT  : waiting for the datapath result
  // OUT   : presenting the ciphertext
  typedef enum logic [2:0] {
    IDLE,
    KEY,
    ISSUE,
    WAIT,
    OUT
  } ctrl_state_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl_if
// Bundles the four handshake channels of the round controller.
//   start channel : start_valid / start_ready / pt_in
//   key channel   : rk_req / rk_idx / rk_ack / rk_data
//   round channel : rnd_valid / rnd_state / rnd_key / rnd_final /
//                   rnd_done / rnd_result
//   output channel: ct_valid / ct_ready / ct_out
// Modports:
//   master : the controller side
//   slave  : the environment (plaintext source, key store, datapath, sink)
// ---------------------------------------------------------------------------
interface aes_round_ctrl_if;
  import aes_pkg::*;

  logic     start_valid;
  logic     start_ready;
  aes_blk_t pt_in;

  logic     rk_req;
  rnd_idx_t rk_idx;
  logic     rk_ack;
  aes_blk_t rk_data;

  logic     rnd_valid;
  aes_blk_t rnd_state;
  aes_blk_t rnd_key;
  logic     rnd_final;
  logic     rnd_done;
  aes_blk_t rnd_result;

  logic     ct_valid;
  logic     ct_ready;
  aes_blk_t ct_out;

  modport master (
    input  start_valid, pt_in, rk_ack, rk_data, rnd_done, rnd_result, ct_ready,
    output start_ready, rk_req, rk_idx, rnd_valid, rnd_state, rnd_key,
           rnd_final, ct_valid, ct_out
  );

  modport slave (
    output start_valid, pt_in, rk_ack, rk_data, rnd_done, rnd_result, ct_ready,
    input  start_ready, rk_req, rk_idx, rnd_valid, rnd_state, rnd_key,
           rnd_final, ct_valid, ct_out
  );

endinterface

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
// Iterative AES-128 encryption sequencer. Takes one plaintext block, applies
// the initial AddRoundKey itself, then walks NR rounds through an external
// shared round datapath, fetching each round key from an external key store.
//
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : aes_round_ctrl_if.master (start / key / round / output)
//   busy_o      : high whenever the FSM is not IDLE
//   round_cnt_o : current round index (0..NR)
//   err_o       : watchdog error, sticky until reset
//
// Parameters:
//   NR          : number of rounds; round NR bypasses MixColumns
//   RND_TIMEOUT : WAIT-cycle limit (only with AES_CTRL_TIMEOUT_EN)
//
// Optional feature, macro AES_CTRL_TIMEOUT_EN:
//   defined   : a watchdog aborts a round after RND_TIMEOUT WAIT cycles without
//               rnd_done, sets err_o, clears the state register, returns IDLE
//   undefined : err_o is tied low and the FSM waits in WAIT indefinitely
// ---------------------------------------------------------------------------
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR_128
`ifdef AES_CTRL_TIMEOUT_EN
  , parameter int RND_TIMEOUT = 64
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  aes_round_ctrl_if.master    bus,
  output logic                busy_o,
  output rnd_idx_t            round_cnt_o,
  output logic                err_o
);

  localparam rnd_idx_t LAST_RND = rnd_idx_t'(NR);

  ctrl_state_e fsm_q, fsm_d;
  aes_blk_t    blk_q, blk_d;
  aes_blk_t    key_q, key_d;
  rnd_idx_t    rnd_q, rnd_d;
  logic        timeout;

`ifdef AES_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(RND_TIMEOUT + 1);

  logic [WD_W-1:0] wdCnt_q, wdCnt_d;
  logic            err_q, err_d;

  // The watchdog fires on the RND_TIMEOUT-th WAIT cycle that still has no
  // rnd_done; a done arriving in that same cycle wins over the timeout.
  assign timeout = (fsm_q == WAIT) && !bus.rnd_done &&
                   (wdCnt_q == WD_W'(RND_TIMEOUT - 1));

  // WAIT is only ever entered from ISSUE, so clearing the counter in ISSUE
  // is the same as clearing it on WAIT entry.
  always_comb begin
    wdCnt_d = wdCnt_q;
    err_d   = err_q | timeout;
    if (fsm_q == ISSUE) begin
      wdCnt_d = '0;
    end else if (fsm_q == WAIT) begin
      wdCnt_d = wdCnt_q + 1'b1;
    end
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdCnt_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wdCnt_q <= wdCnt_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  // State register process: FSM, AES state block, round key and round index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      blk_q <= '0;
      key_q <= '0;
      rnd_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      blk_q <= blk_d;
      key_q <= key_d;
      rnd_q <= rnd_d;
    end
  end

  // Next-state process. Key 0 is never sent to the datapath: it is XORed
  // into the plaintext here and the FSM stays in KEY to fetch key 1.
  // Handshake inputs are only looked at in the state that expects them, so
  // stray rk_ack / rnd_done / ct_ready pulses are ignored.
  always_comb begin
    fsm_d = fsm_q;
    blk_d = blk_q;
    key_d = key_q;
    rnd_d = rnd_q;
    unique case (fsm_q)
      IDLE: begin
        if (bus.start_valid) begin
          blk_d = bus.pt_in;
          rnd_d = '0;
          fsm_d = KEY;
        end
      end
      KEY: begin
        if (bus.rk_ack) begin
          if (rnd_q == '0) begin
            blk_d = blk_q ^ bus.rk_data;
            rnd_d = rnd_idx_t'(1);
          end else begin
            key_d = bus.rk_data;
            fsm_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        fsm_d = WAIT;
      end
      WAIT: begin
        if (bus.rnd_done) begin
          blk_d = bus.rnd_result;
          if (rnd_q == LAST_RND) begin
            fsm_d = OUT;
          end else begin
            rnd_d = rnd_q + 1'b1;
            fsm_d = KEY;
          end
        end else if (timeout) begin
          blk_d = '0;
          fsm_d = IDLE;
        end
      end
      OUT: begin
        if (bus.ct_ready) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // Output process. The datapath and the consumer read the state and key
  // registers directly; they only change on the handshakes above, which
  // keeps rnd_state/rnd_key stable across ISSUE..WAIT and ct_out stable
  // while OUT waits for ct_ready.
  always_comb begin
    bus.start_ready = 1'b0;
    bus.rk_req      = 1'b0;
    bus.rnd_valid   = 1'b0;
    bus.rnd_final   = 1'b0;
    bus.ct_valid    = 1'b0;
    busy_o          = 1'b1;
    unique case (fsm_q)
      IDLE:  begin
        bus.start_ready = 1'b1;
        busy_o          = 1'b0;
      end
      KEY:   bus.rk_req    = 1'b1;
      ISSUE: begin
        bus.rnd_valid = 1'b1;
        bus.rnd_final = (rnd_q == LAST_RND);
      end
      WAIT:  bus.rnd_final = (rnd_q == LAST_RND);
      OUT:   bus.ct_valid  = 1'b1;
      default: busy_o = 1'b1;
    endcase
    bus.rk_idx    = rnd_q;
    bus.rnd_state = blk_q;
    bus.rnd_key   = key_q;
    bus.ct_out    = blk_q;
    round_cnt_o   = rnd_q;
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
// Self-checking bench for aes_round_ctrl. A key store and an AES round
// datapath are modelled around the DUT; expected ciphertexts come from a
// complete AES-128 encryption function (key expansion + rounds) written
// directly from the cipher definition.
// Latency is counted in clock edges from the start handshake edge through
// the edge that raises ct_valid, both inclusive (2 + 3*NR with no stalls).
// Build with +define+AES_CTRL_TIMEOUT_EN to also exercise the watchdog.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam int NR = AES_NR_128;
  localparam aes_blk_t FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam aes_blk_t FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam aes_blk_t FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic     clk;
  logic     rst_n;
  logic     busy;
  rnd_idx_t roundCnt;
  logic     err;

  aes_round_ctrl_if bus();

  aes_round_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy_o     (busy),
    .round_cnt_o(roundCnt),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]          sbox [256];
  logic [11*128-1:0]   keyStore;
  int                  rkDelay      = 0;
  int                  dpLat        = 0;
  bit                  spuriousDone = 0;
  bit                  spuriousAck  = 0;
  bit                  dpEnable     = 1;

  // ---------------- AES reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  // S-box = affine transform of the multiplicative inverse in GF(2^8).
  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [11*128-1:0] expandKey(input aes_blk_t key);
    logic [31:0]        w [44];
    logic [31:0]        tmp;
    logic [7:0]         rc;
    logic [11*128-1:0]  ks;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = subWord({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) ks[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  // Byte i of the block is bits [127-8i -: 8]; byte index = row + 4*column.
  function automatic aes_blk_t aesRound(input aes_blk_t s, input aes_blk_t k,
                                        input logic lastRound);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    aes_blk_t   r;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) t[rw+4*c] = b[rw+4*((c+rw)%4)];
    if (!lastRound) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r ^ k;
  endfunction

  function automatic aes_blk_t aesEncrypt(input aes_blk_t pt, input aes_blk_t key);
    logic [11*128-1:0] ks;
    aes_blk_t          s;
    ks = expandKey(key);
    s  = pt ^ ks[127:0];
    for (int r = 1; r <= NR; r++) s = aesRound(s, ks[r*128 +: 128], r == NR);
    return s;
  endfunction

  // ---------------- comparison ----------------
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // ---------------- key store responder ----------------
  int       kWait;
  bit       kPending;
  rnd_idx_t kIdx;

  // Acks each request after rkDelay idle cycles; a held request must keep
  // its index. With spuriousAck, random acks appear while no request is up.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.rk_ack  = 1'b0;
      bus.rk_data = '0;
      kWait       = 0;
      kPending    = 0;
    end else if (bus.rk_req) begin
      if (kPending) checkOutput("rk_idx_stable", 128'(bus.rk_idx), 128'(kIdx));
      if (kWait >= rkDelay) begin
        bus.rk_ack  = 1'b1;
        bus.rk_data = keyStore[bus.rk_idx*128 +: 128];
        kWait       = 0;
        kPending    = 0;
      end else begin
        bus.rk_ack  = 1'b0;
        bus.rk_data = {4{$urandom}};
        kWait++;
        kPending = 1;
        kIdx     = bus.rk_idx;
      end
    end else begin
      kWait       = 0;
      kPending    = 0;
      bus.rk_ack  = spuriousAck ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.rk_data = {4{$urandom}};
    end
  end

  // ---------------- round datapath responder ----------------
  bit       dpBusy;
  int       dpCnt;
  int       dpRound;
  aes_blk_t dpState;
  aes_blk_t dpKey;
  logic     dpFinal;

  // Captures each issued round, checks rnd_final against the issue count
  // and operand stability, and returns the round result dpLat cycles into
  // WAIT. With spuriousDone, a garbage rnd_done is driven during ISSUE.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.rnd_done   = 1'b0;
      bus.rnd_result = '0;
      dpBusy         = 0;
      dpRound        = 0;
    end else begin
      bus.rnd_done = 1'b0;
      if (bus.start_valid && bus.start_ready) dpRound = 0;
      if (bus.rnd_valid) begin
        dpRound++;
        checkOutput("rnd_final", 128'(bus.rnd_final), 128'(dpRound == NR));
        dpState = bus.rnd_state;
        dpKey   = bus.rnd_key;
        dpFinal = bus.rnd_final;
        dpCnt   = dpLat;
        dpBusy  = dpEnable;
        if (spuriousDone) begin
          bus.rnd_done   = 1'b1;
          bus.rnd_result = {4{$urandom}};
        end
      end else if (dpBusy) begin
        checkOutput("rnd_state_stable", bus.rnd_state, dpState);
        checkOutput("rnd_key_stable", bus.rnd_key, dpKey);
        if (dpCnt == 0) begin
          bus.rnd_done   = 1'b1;
          bus.rnd_result = aesRound(dpState, dpKey, dpFinal);
          dpBusy         = 0;
        end else begin
          dpCnt--;
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  // Offers pt and returns 1 time unit after the start handshake edge.
  task automatic applyStimulus(input aes_blk_t pt);
    bit accepted;
    accepted = 0;
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.pt_in       = pt;
    for (int i = 0; i < 200; i++) begin
      if (bus.start_ready) begin
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) checkOutput("start_accept_timeout", 128'(0), 128'(1));
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    bus.pt_in       = {4{$urandom}};
  endtask

  // Called just after a handshake edge; counts edges until ct_valid is seen.
  task automatic waitCipher(output aes_blk_t ct, output int edges);
    edges = 1;
    while (!bus.ct_valid && edges < 2000) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!bus.ct_valid) checkOutput("ct_valid_timeout", 128'(0), 128'(1));
    ct = bus.ct_out;
  endtask

  task automatic consume();
    @(negedge clk);
    bus.ct_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.ct_ready = 1'b0;
  endtask

  task automatic runBlock(input aes_blk_t pt, input aes_blk_t key, input string tag,
                          input int expLat);
    aes_blk_t ct;
    int       lat;
    keyStore = expandKey(key);
    applyStimulus(pt);
    waitCipher(ct, lat);
    checkOutput({tag, "_ct"}, ct, aesEncrypt(pt, key));
    if (expLat > 0) checkOutput({tag, "_latency"}, 128'(lat), 128'(expLat));
    consume();
    checkOutput({tag, "_ready_after_ct"}, 128'(bus.start_ready), 128'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    aes_blk_t ct;
    aes_blk_t pt2;
    int       lat;
    bit       found;

    buildSbox();
    bus.start_valid = 1'b0;
    bus.pt_in       = '0;
    bus.ct_ready    = 1'b0;
    rst_n           = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_start_ready", 128'(bus.start_ready), 128'(1));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_rk_req", 128'(bus.rk_req), 128'(0));
    checkOutput("rst_rnd_valid", 128'(bus.rnd_valid), 128'(0));
    checkOutput("rst_rnd_final", 128'(bus.rnd_final), 128'(0));
    checkOutput("rst_ct_valid", 128'(bus.ct_valid), 128'(0));
    checkOutput("rst_ct_out", bus.ct_out, 128'(0));
    checkOutput("rst_rnd_key", bus.rnd_key, 128'(0));
    checkOutput("rst_round_cnt", 128'(roundCnt), 128'(0));
    checkOutput("rst_err", 128'(err), 128'(0));
    rst_n = 1'b1;

    $display("[TB] FIPS-197 vector");
    keyStore = expandKey(FIPS_KEY);
    applyStimulus(FIPS_PT);
    waitCipher(ct, lat);
    checkOutput("fips_ct", ct, FIPS_CT);
    checkOutput("fips_latency", 128'(lat), 128'(2 + 3*NR));
    consume();
    checkOutput("fips_ready_after_ct", 128'(bus.start_ready), 128'(1));

    $display("[TB] key-store stalls");
    rkDelay = 3;
    runBlock(FIPS_PT, FIPS_KEY, "stall", 2 + 3*NR + 3*(NR + 1));
    rkDelay = 0;

    $display("[TB] output backpressure and busy start");
    keyStore = expandKey(FIPS_KEY);
    applyStimulus(FIPS_PT);
    waitCipher(ct, lat);
    checkOutput("bp_ct", ct, FIPS_CT);
    pt2             = {4{$urandom}};
    bus.start_valid = 1'b1;
    bus.pt_in       = pt2;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_ct_stable", bus.ct_out, FIPS_CT);
      checkOutput("bp_ct_valid", 128'(bus.ct_valid), 128'(1));
      checkOutput("bp_start_ready_low", 128'(bus.start_ready), 128'(0));
    end
    bus.ct_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.ct_ready = 1'b0;
    checkOutput("bp_ready_after_ct", 128'(bus.start_ready), 128'(1));
    checkOutput("bp_ct_valid_drop", 128'(bus.ct_valid), 128'(0));
    checkOutput("bp_busy_idle", 128'(busy), 128'(0));
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    checkOutput("bp_second_accepted", 128'(busy), 128'(1));
    checkOutput("bp_second_ready_low", 128'(bus.start_ready), 128'(0));
    waitCipher(ct, lat);
    checkOutput("bp_second_ct", ct, aesEncrypt(pt2, FIPS_KEY));
    checkOutput("bp_second_latency", 128'(lat), 128'(2 + 3*NR));
    consume();

    $display("[TB] spurious datapath done");
    spuriousDone = 1;
    runBlock({4{$urandom}}, FIPS_KEY, "spurious", 2 + 3*NR);
    spuriousDone = 0;

    $display("[TB] randomized blocks");
    spuriousAck = 1;
    for (int n = 0; n < 4; n++) begin
      rkDelay = $urandom_range(0, 2);
      dpLat   = $urandom_range(0, 3);
      runBlock({4{$urandom}}, {4{$urandom}}, "random", 0);
    end
    spuriousAck = 0;
    rkDelay     = 0;
    dpLat       = 0;

    $display("[TB] reset mid-round");
    dpLat    = 4;
    keyStore = expandKey(FIPS_KEY);
    applyStimulus({4{$urandom}});
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (roundCnt == rnd_idx_t'(5) && busy && !bus.rk_req && !bus.rnd_valid) begin
        found = 1;
        break;
      end
    end
    checkOutput("mid_reset_reached_wait", 128'(found), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_busy", 128'(busy), 128'(0));
    checkOutput("mid_reset_ct_valid", 128'(bus.ct_valid), 128'(0));
    checkOutput("mid_reset_round_cnt", 128'(roundCnt), 128'(0));
    checkOutput("mid_reset_start_ready", 128'(bus.start_ready), 128'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dpLat = 0;
    runBlock(FIPS_PT, FIPS_KEY, "after_reset", 2 + 3*NR);

`ifdef AES_CTRL_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    dpEnable = 0;
    keyStore = expandKey(FIPS_KEY);
    applyStimulus(FIPS_PT);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.rnd_valid) begin
        found = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("wd_issue_seen", 128'(found), 128'(1));
    @(posedge clk);
    repeat (63) @(posedge clk);
    #1;
    checkOutput("wd_err_before", 128'(err), 128'(0));
    checkOutput("wd_busy_before", 128'(busy), 128'(1));
    @(posedge clk);
    #1;
    checkOutput("wd_err_set", 128'(err), 128'(1));
    checkOutput("wd_start_ready", 128'(bus.start_ready), 128'(1));
    checkOutput("wd_ct_valid", 128'(bus.ct_valid), 128'(0));
    checkOutput("wd_state_cleared", bus.ct_out, 128'(0));
    dpEnable = 1;
    runBlock(FIPS_PT, FIPS_KEY, "wd_recover", 2 + 3*NR);
    checkOutput("wd_err_sticky", 128'(err), 128'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("wd_err_reset", 128'(err), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if some wait above never completes.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
